// File: rtl/dpll_core_pkg.sv
// Shared definitions for the digital PLL core: mode encodings, default
// parameter values and the correction clamp.
package dpll_core_pkg;

   localparam logic MODE_BANG = 1'b0;
   localparam logic MODE_PROP = 1'b1;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_DIV         = 200;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_MAX_ADJ     = 8;
   localparam int DEF_GAIN_SHIFT  = 2;
   localparam int DEF_LOCK_WIN    = 2;
   localparam int DEF_LOCK_CNT    = 8;
   localparam int DEF_MISS_MAX    = 4;

   function automatic int clamp_adj(input int val, input int lim);
      int res;
      if (val > lim) begin
         res = lim;
      end else if (val < -lim) begin
         res = -lim;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/dpll_core_edge_sync.sv
// Synchroniser chain for the asynchronous reference plus a registered
// rising-edge detector; a rise shows up on edge_pulse_o SYNC_STAGES+1 cycles later.
module edge_sync
   import dpll_core_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic signal_i,
   output logic edge_pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   pulse_q;

   // shift the reference through the synchroniser and strobe on a 0->1 step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= {SYNC_STAGES{1'b0}};
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_i};
         prev_q  <= sync_q[SYNC_STAGES-1];
         pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign edge_pulse_o = pulse_q;

endmodule

// File: rtl/dpll_core.sv
// All-digital PLL core: programmable-period phase counter steered by a signed
// phase detector (bang-bang or proportional) with a lock/loss detector.
module dpll_core
   import dpll_core_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DIV         = DEF_DIV,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int MAX_ADJ     = DEF_MAX_ADJ,
   parameter int GAIN_SHIFT  = DEF_GAIN_SHIFT,
   parameter int LOCK_WIN    = DEF_LOCK_WIN,
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int MISS_MAX    = DEF_MISS_MAX
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   mode,
   input  logic                   signal,
   output logic                   clk_out,
   output logic                   edge_pulse,
   output logic signed [CNT_W:0]  phase_err,
   output logic                   err_valid,
   output logic                   locked
);

   localparam int STREAK_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W   = $clog2(MISS_MAX + 1);
   localparam logic [CNT_W-1:0]        DIV_C     = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]        HALF_C    = CNT_W'(DIV / 2);
   localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]        CNT_ZERO  = CNT_W'(0);
   localparam logic signed [CNT_W:0]   ERR_ZERO  = (CNT_W+1)'(0);
   localparam logic [STREAK_W-1:0]     LOCK_C    = STREAK_W'(LOCK_CNT);
   localparam logic [STREAK_W-1:0]     STR_ONE   = STREAK_W'(1);
   localparam logic [STREAK_W-1:0]     STR_ZERO  = STREAK_W'(0);
   localparam logic [MISS_W-1:0]       MISS_C    = MISS_W'(MISS_MAX);
   localparam logic [MISS_W-1:0]       MISS_ONE  = MISS_W'(1);
   localparam logic [MISS_W-1:0]       MISS_ZERO = MISS_W'(0);

   logic [CNT_W-1:0]       cnt_q, cnt_d, len_q, len_d;
   logic signed [CNT_W:0]  pend_q, pend_d, phase_err_q, phase_err_d, err_s;
   logic [STREAK_W-1:0]    streak_q, streak_d;
   logic [MISS_W-1:0]      miss_q, miss_d;
   logic                   clk_out_q, clk_out_d, locked_q, locked_d, err_valid_q, err_valid_d;
   logic                   edge_s, wrap_s, in_win_s;
   int                     err_int_s, adj_int_s, len_int_s;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk          (clk),
      .reset_n      (reset_n),
      .signal_i     (signal),
      .edge_pulse_o (edge_s)
   );

   // phase error relative to the nearest local wrap, and the correction it implies
   always_comb begin
      if (cnt_q < HALF_C) begin
         err_s = $signed({1'b0, cnt_q});
      end else begin
         err_s = $signed({1'b0, cnt_q}) - $signed({1'b0, len_q});
      end
      err_int_s = int'(err_s);
      if (mode == MODE_PROP) begin
         adj_int_s = clamp_adj(err_int_s >>> GAIN_SHIFT, MAX_ADJ);
      end else if (err_int_s > 32'sd0) begin
         adj_int_s = 32'sd1;
      end else if (err_int_s < 32'sd0) begin
         adj_int_s = -32'sd1;
      end else begin
         adj_int_s = 32'sd0;
      end
      in_win_s  = (err_int_s <= LOCK_WIN) && (err_int_s >= -LOCK_WIN);
      len_int_s = DIV + int'(pend_q);
      wrap_s    = (cnt_q >= (len_q - CNT_ONE));
   end

   // next-state for counter, period, correction and lock tracking
   always_comb begin
      cnt_d       = cnt_q;
      len_d       = len_q;
      pend_d      = pend_q;
      streak_d    = streak_q;
      miss_d      = miss_q;
      clk_out_d   = clk_out_q;
      locked_d    = locked_q;
      phase_err_d = phase_err_q;
      err_valid_d = 1'b0;
      if (!enable) begin
         cnt_d     = CNT_ZERO;
         len_d     = DIV_C;
         pend_d    = ERR_ZERO;
         streak_d  = STR_ZERO;
         miss_d    = MISS_ZERO;
         clk_out_d = 1'b0;
         locked_d  = 1'b0;
      end else begin
         clk_out_d = (cnt_q < HALF_C);
         if (wrap_s) begin
            cnt_d  = CNT_ZERO;
            len_d  = len_int_s[CNT_W-1:0];
            pend_d = ERR_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
         // an edge on the wrap cycle stores its correction for the following wrap
         if (edge_s) begin
            pend_d      = adj_int_s[CNT_W:0];
            phase_err_d = err_s;
            err_valid_d = 1'b1;
            miss_d      = MISS_ZERO;
            if (in_win_s) begin
               if (streak_q != LOCK_C) begin
                  streak_d = streak_q + STR_ONE;
               end else begin
                  streak_d = streak_q;
               end
               if (streak_d == LOCK_C) begin
                  locked_d = 1'b1;
               end else begin
                  locked_d = locked_q;
               end
            end else begin
               streak_d = STR_ZERO;
               locked_d = 1'b0;
            end
         end else if (wrap_s) begin
            if (miss_q != MISS_C) begin
               miss_d = miss_q + MISS_ONE;
            end else begin
               miss_d = miss_q;
            end
            if (miss_d == MISS_C) begin
               locked_d = 1'b0;
               streak_d = STR_ZERO;
            end else begin
               locked_d = locked_q;
            end
         end else begin
            miss_d = miss_q;
         end
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= CNT_ZERO;
         len_q       <= DIV_C;
         pend_q      <= ERR_ZERO;
         streak_q    <= STR_ZERO;
         miss_q      <= MISS_ZERO;
         clk_out_q   <= 1'b0;
         locked_q    <= 1'b0;
         phase_err_q <= ERR_ZERO;
         err_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         pend_q      <= pend_d;
         streak_q    <= streak_d;
         miss_q      <= miss_d;
         clk_out_q   <= clk_out_d;
         locked_q    <= locked_d;
         phase_err_q <= phase_err_d;
         err_valid_q <= err_valid_d;
      end
   end

   assign clk_out    = clk_out_q;
   assign edge_pulse = edge_s;
   assign phase_err  = phase_err_q;
   assign err_valid  = err_valid_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_dpll_core.sv
// Self-checking bench for dpll_core: per-cycle comparison against a behavioural
// model, a table of single-edge correction cases and multi-cycle lock/loss sequences.
module tb_dpll_core;
   import dpll_core_pkg::*;

   localparam int CNT_W = 16, DIV = 200, MAX_ADJ = 8, GAIN_SHIFT = 2;
   localparam int LOCK_WIN = 2, LOCK_CNT = 8, MISS_MAX = 4;

   logic clk = 1'b0;
   logic reset_n, enable, mode, signal;
   logic clk_out, edge_pulse, err_valid, locked;
   logic signed [CNT_W:0] phase_err;

   always #5 clk = ~clk;

   dpll_core #(
      .CNT_W(CNT_W), .DIV(DIV), .SYNC_STAGES(2), .MAX_ADJ(MAX_ADJ), .GAIN_SHIFT(GAIN_SHIFT),
      .LOCK_WIN(LOCK_WIN), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .signal(signal),
      .clk_out(clk_out), .edge_pulse(edge_pulse), .phase_err(phase_err),
      .err_valid(err_valid), .locked(locked)
   );

   int checks = 0;
   int errors = 0;

   // behavioural reference state
   int m_hist[3];
   int m_cnt, m_len, m_pend, m_streak, m_miss;
   int m_clk, m_pulse, m_err, m_ev, m_lock;

   typedef struct { int md; int x; int exp_err; int exp_len; } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 3; i++) m_hist[i] = 0;
      m_cnt = 0; m_len = DIV; m_pend = 0; m_streak = 0; m_miss = 0;
      m_clk = 0; m_pulse = 0; m_err = 0; m_ev = 0; m_lock = 0;
   endtask

   function automatic int correction(input int e, input int md);
      int a;
      if (md == 1) begin
         // arithmetic shift == floor division by 2**GAIN_SHIFT
         if (e >= 0) a = e / (1 << GAIN_SHIFT);
         else a = -((-e + (1 << GAIN_SHIFT) - 1) / (1 << GAIN_SHIFT));
         if (a > MAX_ADJ) a = MAX_ADJ;
         if (a < -MAX_ADJ) a = -MAX_ADJ;
      end else begin
         a = (e > 0) ? 1 : ((e < 0) ? -1 : 0);
      end
      return a;
   endfunction

   // advance the model by one clock using the inputs sampled at this edge
   task automatic m_step();
      int p, c, e, wrapped;
      p = m_pulse;
      m_pulse = (m_hist[1] == 1 && m_hist[2] == 0) ? 1 : 0;
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = int'(signal);
      m_ev = 0;
      if (!enable) begin
         m_cnt = 0; m_len = DIV; m_pend = 0; m_streak = 0; m_miss = 0; m_clk = 0; m_lock = 0;
      end else begin
         c = m_cnt;
         e = (c < DIV / 2) ? c : c - m_len;
         m_clk = (c < DIV / 2) ? 1 : 0;
         wrapped = (c == m_len - 1) ? 1 : 0;
         if (wrapped == 1) begin
            m_cnt = 0; m_len = DIV + m_pend; m_pend = 0;
         end else m_cnt = c + 1;
         if (p == 1) begin
            m_pend = correction(e, int'(mode)); m_err = e; m_ev = 1; m_miss = 0;
            if (e <= LOCK_WIN && e >= -LOCK_WIN) begin
               if (m_streak < LOCK_CNT) m_streak++;
               if (m_streak == LOCK_CNT) m_lock = 1;
            end else begin
               m_streak = 0; m_lock = 0;
            end
         end else if (wrapped == 1) begin
            if (m_miss < MISS_MAX) m_miss++;
            if (m_miss == MISS_MAX) begin m_lock = 0; m_streak = 0; end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      m_step();
      #1;
      check("clk_out", int'(clk_out), m_clk);
      check("edge_pulse", int'(edge_pulse), m_pulse);
      check("phase_err", int'(phase_err), m_err);
      check("err_valid", int'(err_valid), m_ev);
      check("locked", int'(locked), m_lock);
   endtask

   task automatic rise_to_rise(output int n);
      logic pv;
      int guard;
      guard = 0;
      pv = clk_out;
      while (!(pv == 1'b0 && clk_out == 1'b1) && guard < 500) begin
         pv = clk_out; step(); guard++;
      end
      if (guard >= 500) begin
         errors++;
         $display("FAIL clk_out_rise_timeout actual=none required=rise");
      end
      n = 0;
      do begin
         pv = clk_out; step(); n++;
      end while (!(pv == 1'b0 && clk_out == 1'b1) && n < 500);
   endtask

   int n, hi, cyc, nev, per, skip;

   initial begin
      tbl[0] = '{0, 10, 10, 201};
      tbl[1] = '{0, 150, -50, 199};
      tbl[2] = '{1, 40, 40, 208};
      tbl[3] = '{1, 190, -10, 197};
      tbl[4] = '{1, 5, 5, 201};
      tbl[5] = '{1, 100, -100, 192};
      tbl[6] = '{1, 99, 99, 208};
      tbl[7] = '{0, 60, 60, 201};

      reset_n = 1'b0; enable = 1'b0; mode = 1'b0; signal = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_phase_err", int'(phase_err), 0);
      check("rst_err_valid", int'(err_valid), 0);
      reset_n = 1'b1;

      // idle: edge detector runs, loop outputs stay 0
      for (int r = 0; r < 3; r++) begin
         signal = 1'b1;
         n = 0;
         do begin step(); n++; end while (!edge_pulse && n < 10);
         check("idle_pulse_latency", n, 3);
         signal = 1'b0;
         repeat (6) step();
      end

      // free run with no reference
      enable = 1'b1;
      repeat (205) step();
      hi = 0;
      for (int i = 0; i < 200; i++) begin step(); hi += int'(clk_out); end
      check("freerun_high", hi, 100);
      rise_to_rise(n);
      check("freerun_period", n, 200);
      repeat (700) step();
      check("freerun_locked", int'(locked), 0);

      // single-edge correction table
      for (int t = 0; t < 8; t++) begin
         enable = 1'b0; signal = 1'b0; mode = tbl[t].md[0];
         repeat (5) step();
         enable = 1'b1;
         repeat (tbl[t].x - 3) step();
         signal = 1'b1;
         repeat (3) step();
         check("tbl_edge_pulse", int'(edge_pulse), 1);
         step();
         check("tbl_err_valid", int'(err_valid), 1);
         check("tbl_phase_err", int'(phase_err), tbl[t].exp_err);
         signal = 1'b0;
         rise_to_rise(n);
         check("tbl_next_period", n, tbl[t].exp_len);
      end

      // aligned reference: zero error, lock on 8th edge, then loss after 4 missed wraps
      enable = 1'b0; signal = 1'b0; mode = MODE_BANG;
      repeat (5) step();
      enable = 1'b1; cyc = 0; nev = 0;
      while (nev < 10 && cyc < 3000) begin
         signal = (cyc >= 197) && (((cyc - 197) % 200) < 100);
         step(); cyc++;
         if (err_valid) begin
            nev++;
            check("aligned_err", int'(phase_err), 0);
            if (nev == 7) check("aligned_lock7", int'(locked), 0);
            if (nev == 8) check("aligned_lock8", int'(locked), 1);
         end
      end
      check("aligned_edges", nev, 10);
      signal = 1'b0;
      repeat (798) step();
      check("loss_before", int'(locked), 1);
      step();
      check("loss_after", int'(locked), 0);

      // bang-bang pull-in from +10
      enable = 1'b0; signal = 1'b0; mode = MODE_BANG;
      repeat (5) step();
      enable = 1'b1; cyc = 0; nev = 0;
      while (!locked && cyc < 8000) begin
         signal = (cyc >= 7) && (((cyc - 7) % 200) < 100);
         step(); cyc++;
         if (err_valid) begin
            if (nev == 0) check("bang_first_err", int'(phase_err), 10);
            nev++;
         end
      end
      check("bang_lock", int'(locked), 1);
      repeat (50) begin
         signal = (((cyc - 7) % 200) < 100);
         step(); cyc++;
      end

      // asynchronous reset mid-period
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_locked", int'(locked), 0);
      check("async_rst_clk_out", int'(clk_out), 0);
      check("async_rst_phase_err", int'(phase_err), 0);
      check("async_rst_err_valid", int'(err_valid), 0);
      check("async_rst_edge_pulse", int'(edge_pulse), 0);
      signal = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // randomized reference with jitter, mode flips, dropped edges and enable glitches
      enable = 1'b1;
      for (int p = 0; p < 40; p++) begin
         per  = $urandom_range(185, 215);
         mode = 1'($urandom_range(0, 1));
         skip = ($urandom_range(0, 7) == 0) ? 1 : 0;
         for (int i = 0; i < per; i++) begin
            signal = (skip == 0) && (i < per / 2);
            if ($urandom_range(0, 999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
